// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind valid/ready request and response channels,
// one request outstanding, with LATENCY programmable wait cycles before the response.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] Limit = 32'(4 * DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic          acc_err;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;

  // With zero latency the access happens on the accept edge itself, so the
  // operands come straight from the request port instead of the latches.
  always_comb begin
    accept     = req_valid && req_ready;
    acc_we     = (state == StIdle) ? req_we    : we_q;
    acc_addr   = (state == StIdle) ? req_addr  : addr_q;
    acc_wdata  = (state == StIdle) ? req_wdata : wdata_q;
    acc_idx    = acc_addr[AW+1:2];
    acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr >= Limit);
    enter_resp = ((state == StIdle) && accept && (LATENCY == 0)) ||
                 ((state == StWait) && (cnt == 4'd1));
  end

  // Reset wins over a commit on the same edge, so an abandoned store is never written.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY != 0) begin
              state <= StWait;
              cnt   <= 4'(LATENCY);
            end
          end
        end
        StWait: begin
          cnt <= cnt - 4'd1;
        end
        StResp: begin
          if (resp_ready) begin
            state      <= StIdle;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase

      if (enter_resp) begin
        state      <= StResp;
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        resp_rdata <= (acc_we || acc_err) ? '0 : mem[acc_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 with LATENCY=2, instance 1 with LATENCY=0.
module tb_dmem_responder;

  localparam int unsigned LatA = 2;
  localparam int unsigned LatB = 0;

  typedef struct {
    int          k;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(LatA)) u_dut_a (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(LatB)) u_dut_b (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? int'(LatA) : int'(LatB);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-port latency, hold, idle-zero, ordering and burst-spacing checks.
  int               acc_cyc [2];
  int               last_hs [2];
  logic [1:0]       pv, pend, stall, bseen, burst;
  logic [1:0][31:0] hold_rd;
  logic [1:0]       hold_err;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pv[k]    = 1'b0;
        pend[k]  = 1'b0;
        stall[k] = 1'b0;
        bseen[k] = 1'b0;
      end else begin
        if (stall[k]) begin
          check("hold_valid", 32'(resp_valid[k]), 32'd1);
          check("hold_rdata", resp_rdata[k], hold_rd[k]);
          check("hold_err", 32'(resp_err[k]), 32'(hold_err[k]));
        end
        if (req_valid[k] && req_ready[k]) begin
          if (pend[k]) check("accept_after_resp", 32'(cyc), 32'(last_hs[k] + 1));
          acc_cyc[k] = cyc;
        end
        if (resp_valid[k] && !pv[k]) begin
          check("resp_latency", 32'(cyc - acc_cyc[k]), 32'(lat(k) + 1));
        end
        if (!resp_valid[k]) begin
          check("idle_rdata_zero", resp_rdata[k], 32'd0);
          check("idle_err_zero", 32'(resp_err[k]), 32'd0);
        end
        if (resp_valid[k] && resp_ready[k]) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: port %0d responded, expected no response", k);
          end else begin
            e = sb.pop_front();
            check("resp_port", 32'(k), 32'(e.k));
            check("resp_rdata", resp_rdata[k], e.rd);
            check("resp_err", 32'(resp_err[k]), 32'(e.err));
          end
          if (burst[k] && bseen[k]) check("burst_spacing", 32'(cyc - last_hs[k]), 32'd2);
          bseen[k]   = burst[k];
          last_hs[k] = cyc;
        end
        pend[k]     = req_valid[k] && !req_ready[k];
        pv[k]       = resp_valid[k];
        stall[k]    = resp_valid[k] && !resp_ready[k];
        hold_rd[k]  = resp_rdata[k];
        hold_err[k] = resp_err[k];
      end
    end
  end

  task automatic req(input int k, input bit push, input bit keep, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exd, input logic exe);
    int n = 0;
    if (push) sb.push_back('{k, exd, exe});
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready[k]) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout: port %0d req_ready 0, expected 1", k);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '1;
    burst      = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_req_ready", 32'(req_ready[k]), 32'd1);
      check("reset_resp_valid", 32'(resp_valid[k]), 32'd0);
      check("reset_resp_rdata", resp_rdata[k], 32'd0);
      check("reset_resp_err", 32'(resp_err[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Store then load back.
    req(0, 1, 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req(0, 1, 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();

    // Errors: misaligned, out of range, and a rejected store must not alias word 0.
    req(0, 1, 0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    req(0, 1, 0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    req(0, 1, 0, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0);
    req(0, 1, 0, 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    req(0, 1, 0, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
    req(0, 1, 0, 1'b1, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0);
    req(0, 1, 0, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);
    req(0, 1, 0, 1'b1, 32'h104, 32'h1, 32'h0, 1'b1);
    req(0, 1, 0, 1'b1, 32'h3, 32'h2, 32'h0, 1'b1);
    req(0, 1, 0, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
    drain();

    // Backpressure with a second request held pending.
    resp_ready[0] = 1'b0;
    req(0, 1, 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    fork
      begin
        repeat (8) @(posedge clk);
        #1;
        resp_ready[0] = 1'b1;
      end
      req(0, 1, 0, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);
    join
    drain();

    // Reset during WAIT abandons the store.
    req(0, 1, 0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
    drain();
    req(0, 0, 0, 1'b1, 32'h20, 32'h55, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midwait_reset_req_ready", 32'(req_ready[0]), 32'd1);
    check("midwait_reset_resp_valid", 32'(resp_valid[0]), 32'd0);
    rst_n = 1'b1;
    req(0, 1, 0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
    drain();

    // Zero-latency instance: preload, then back-to-back loads with valid held high.
    for (int i = 0; i < 4; i++) begin
      req(1, 1, 0, 1'b1, 32'(4 * i), 32'hB0000000 + 32'(i), 32'h0, 1'b0);
    end
    drain();
    burst[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req(1, 1, 1, 1'b0, 32'(4 * i), 32'h0, 32'hB0000000 + 32'(i), 1'b0);
    end
    req(1, 1, 1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
    req_valid[1] = 1'b0;
    drain();
    burst[1] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
